// File: rtl/cookie_scan_ctrl_if.sv
// cookie_scan_ctrl_if: cookie position ROM read port plus renderer visibility query.
// Latency: Rom_x/Rom_y return one cycle after Rom_addr; Draw_visible is combinational.
// Backpressure: none; the ROM and renderer are always ready.
// Signals: Rom_addr (ctrl->ROM), Rom_x/Rom_y (ROM->ctrl),
//          Draw_idx (renderer->ctrl), Draw_visible (ctrl->renderer).
interface cookie_scan_ctrl_if #(
  parameter int IDX_W = 6
) ();
  logic [IDX_W-1:0] Rom_addr;
  logic [9:0]       Rom_x;
  logic [9:0]       Rom_y;
  logic [IDX_W-1:0] Draw_idx;
  logic             Draw_visible;

  // master: the scan controller; slave: ROM + renderer side
  modport master (
    output Rom_addr,
    input  Rom_x,
    input  Rom_y,
    input  Draw_idx,
    output Draw_visible
  );

  modport slave (
    input  Rom_addr,
    output Rom_x,
    output Rom_y,
    output Draw_idx,
    input  Draw_visible
  );
endinterface

// File: rtl/cookie_scan_ctrl.sv
// cookie_scan_ctrl: time-shares one pac-man/cookie overlap comparator across all cookies once per frame.
// Latency: scan lasts NUM_COOKIES+1 cycles; cookie k is resolved at edge T+2+k after Frame_tick at T.
// Backpressure: none; Frame_tick outside IDLE is dropped, Level_restart aborts and wins over Frame_tick.
// Ports: Clk, Reset (async, active-high); Frame_tick, Level_restart strobes; Xp/Yp/Sizep pac-man box;
//        Bus (cookie_scan_ctrl_if.master: ROM address/data, renderer query); Eat_pulse, Score,
//        Scan_busy, Scan_done, Level_clear status. Optional macro COOKIE_POWER_PELLET_EN makes
//        cookies 0..3 worth 50 points and adds the Power_pulse output.
module cookie_scan_ctrl #(
  parameter int NUM_COOKIES = 64,
  parameter int IDX_W       = 6,
  parameter int SCORE_W     = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Frame_tick,
  input  logic               Level_restart,
  input  logic [9:0]         Xp,
  input  logic [9:0]         Yp,
  input  logic [9:0]         Sizep,
  cookie_scan_ctrl_if.master Bus,
  output logic               Eat_pulse,
`ifdef COOKIE_POWER_PELLET_EN
  output logic               Power_pulse,
`endif
  output logic [SCORE_W-1:0] Score,
  output logic               Scan_busy,
  output logic               Scan_done,
  output logic               Level_clear
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COOKIES - 1);

  state_t                 state_q;
  state_t                 state_d;
  logic                   start;
  logic                   scan_end;

  logic [IDX_W-1:0]       rom_addr_q;
  logic                   vld_q;
  logic [IDX_W-1:0]       idx_q;
  logic [9:0]             x_q;
  logic [9:0]             y_q;
  logic [9:0]             half_q;

  logic [NUM_COOKIES-1:0] bitmap_q;

  logic signed [10:0]     dx;
  logic signed [10:0]     dy;
  logic [10:0]            adx;
  logic [10:0]            ady;
  logic                   hit;
  logic                   eat;
  logic [5:0]             points;
  logic [SCORE_W:0]       score_sum;
  logic [SCORE_W-1:0]     score_next;

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    scan_end = 1'b0;
    case (state_q)
      IDLE: begin
        // a restart in the same cycle swallows the frame strobe
        if (Frame_tick && !Level_restart) begin
          state_d = SCAN;
          start   = 1'b1;
        end
      end
      SCAN: begin
        if (Level_restart) begin
          state_d = IDLE;
        end else if (rom_addr_q == LAST_IDX) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // last cookie is being compared this cycle; an abort here also kills Scan_done
        state_d  = IDLE;
        scan_end = !Level_restart;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Scan_busy = (state_q != IDLE);

  // ---------------------------------------------------------------------------
  // ROM address walk, compare tag and pac-man snapshot
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rom_addr_q <= '0;
      vld_q      <= 1'b0;
      idx_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      half_q     <= '0;
    end else begin
      // tag follows the address by one cycle, matching the ROM's read latency
      vld_q <= (state_q == SCAN) && !Level_restart;
      idx_q <= rom_addr_q;
      if (start) begin
        rom_addr_q <= '0;
        x_q        <= Xp;
        y_q        <= Yp;
        half_q     <= Sizep >> 1;
      end else if ((state_q == SCAN) && !Level_restart && (rom_addr_q != LAST_IDX)) begin
        rom_addr_q <= rom_addr_q + 1'b1;
      end
    end
  end

  assign Bus.Rom_addr = rom_addr_q;

  // ---------------------------------------------------------------------------
  // Overlap comparator: 11-bit signed differences so 0/1023 never wrap
  // ---------------------------------------------------------------------------
  assign dx  = $signed({1'b0, x_q}) - $signed({1'b0, Bus.Rom_x});
  assign dy  = $signed({1'b0, y_q}) - $signed({1'b0, Bus.Rom_y});
  assign adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
  assign ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);
  assign hit = (adx <= {1'b0, half_q}) && (ady <= {1'b0, half_q});

  // only uneaten cookies score; a restart in flight suppresses the eat
  assign eat = vld_q && hit && bitmap_q[idx_q] && !Level_restart;

`ifdef COOKIE_POWER_PELLET_EN
  logic is_pellet;
  assign is_pellet = (32'(idx_q) < 32'd4);
  assign points    = is_pellet ? 6'd50 : 6'd10;
`else
  assign points    = 6'd10;
`endif

  // one extra bit catches the carry; on overflow the score pins at all-ones
  assign score_sum  = {1'b0, Score} + {{(SCORE_W-5){1'b0}}, points};
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  // ---------------------------------------------------------------------------
  // Eaten bitmap, score and status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bitmap_q    <= '1;
      Score       <= '0;
      Eat_pulse   <= 1'b0;
      Scan_done   <= 1'b0;
      Level_clear <= 1'b0;
    end else begin
      Eat_pulse   <= eat;
      Scan_done   <= scan_end;
      Level_clear <= (bitmap_q == '0);
      if (Level_restart) begin
        bitmap_q <= '1;
      end else if (eat) begin
        bitmap_q[idx_q] <= 1'b0;
      end
      if (eat) begin
        Score <= score_next;
      end
    end
  end

`ifdef COOKIE_POWER_PELLET_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Power_pulse <= 1'b0;
    end else begin
      Power_pulse <= eat && is_pellet;
    end
  end
`endif

  // renderer sees the registered bitmap; indices past the last cookie read as not visible
  assign Bus.Draw_visible = (32'(Bus.Draw_idx) < NUM_COOKIES) && bitmap_q[Bus.Draw_idx];

endmodule

// File: tb/tb_cookie_scan_ctrl.sv
// tb_cookie_scan_ctrl: directed bench for cookie_scan_ctrl with a schedule-level reference model.
// Latency: model resolves cookie k at edge T+2+k of a scan started at edge T.
// Backpressure: not applicable; ROM model answers every address one cycle later.
module tb_cookie_scan_ctrl;
  localparam int N       = 64;
  localparam int IDX_W   = 6;
  localparam int SCORE_W = 16;
  localparam int SMAX    = 65535;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Frame_tick;
  logic       Level_restart;
  logic [9:0] Xp;
  logic [9:0] Yp;
  logic [9:0] Sizep;
  logic       Eat_pulse;
  logic [SCORE_W-1:0] Score;
  logic       Scan_busy;
  logic       Scan_done;
  logic       Level_clear;
`ifdef COOKIE_POWER_PELLET_EN
  logic       Power_pulse;
`endif

  cookie_scan_ctrl_if #(.IDX_W(IDX_W)) bus ();

  cookie_scan_ctrl #(.NUM_COOKIES(N), .IDX_W(IDX_W), .SCORE_W(SCORE_W)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Frame_tick   (Frame_tick),
    .Level_restart(Level_restart),
    .Xp           (Xp),
    .Yp           (Yp),
    .Sizep        (Sizep),
    .Bus          (bus),
    .Eat_pulse    (Eat_pulse),
`ifdef COOKIE_POWER_PELLET_EN
    .Power_pulse  (Power_pulse),
`endif
    .Score        (Score),
    .Scan_busy    (Scan_busy),
    .Scan_done    (Scan_done),
    .Level_clear  (Level_clear)
  );

  always #5 Clk = ~Clk;

  // cookie position ROM with one-cycle registered read
  int rom_x [N];
  int rom_y [N];
  always @(posedge Clk) begin
    bus.Rom_x <= 10'(rom_x[bus.Rom_addr]);
    bus.Rom_y <= 10'(rom_y[bus.Rom_addr]);
  end

  // reference model state
  int          cyc;
  bit          m_active;
  int          m_t;
  int          m_px, m_py, m_hf;
  logic [N-1:0] m_bmp;
  int          m_score;
  bit          m_eat, m_done, m_busy, m_lc, m_pow;

  // observation counters
  int busy_cnt, done_cnt, eat_cnt, pow_cnt, last_eat;
  int checks, errors;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_hit(input int px, input int py, input int hf, input int rx, input int ry);
    int ax;
    int ay;
    ax = (px > rx) ? px - rx : rx - px;
    ay = (py > ry) ? py - ry : ry - py;
    return (ax <= hf) && (ay <= hf);
  endfunction

  // what the outputs must be after the edge just taken
  task automatic model_edge();
    int n;
    int k;
    int pts;
    cyc++;
    m_eat  = 1'b0;
    m_done = 1'b0;
    m_pow  = 1'b0;
    if (Reset) begin
      m_active = 1'b0;
      m_bmp    = '1;
      m_score  = 0;
      m_lc     = 1'b0;
      m_busy   = 1'b0;
    end else begin
      m_lc = (m_bmp == '0);
      if (Level_restart) begin
        m_bmp    = '1;
        m_active = 1'b0;
      end else if (m_active) begin
        n = cyc - m_t;
        if (n >= 2) begin
          k = n - 2;
          if (m_bmp[k] && model_hit(m_px, m_py, m_hf, rom_x[k], rom_y[k])) begin
            pts = 10;
`ifdef COOKIE_POWER_PELLET_EN
            if (k < 4) begin
              pts   = 50;
              m_pow = 1'b1;
            end
`endif
            m_eat    = 1'b1;
            m_bmp[k] = 1'b0;
            m_score  = (m_score + pts > SMAX) ? SMAX : m_score + pts;
          end
        end
        if (n == N + 1) begin
          m_done   = 1'b1;
          m_active = 1'b0;
        end
      end else if (Frame_tick) begin
        m_active = 1'b1;
        m_t      = cyc;
        m_px     = int'(Xp);
        m_py     = int'(Yp);
        m_hf     = int'(Sizep) / 2;
      end
      m_busy = m_active;
    end
  endtask

  task automatic compare();
    int n;
    chk("scan_busy", Scan_busy, m_busy);
    chk("scan_done", Scan_done, m_done);
    chk("eat_pulse", Eat_pulse, m_eat);
    chk("score", Score, m_score);
    chk("level_clear", Level_clear, m_lc);
    chk("draw_visible", bus.Draw_visible, m_bmp[bus.Draw_idx]);
    if (m_busy) begin
      n = cyc - m_t;
      chk("rom_addr", bus.Rom_addr, (n < N - 1) ? n : N - 1);
    end
`ifdef COOKIE_POWER_PELLET_EN
    chk("power_pulse", Power_pulse, m_pow);
    if (Power_pulse && Eat_pulse) pow_cnt++;
`endif
    busy_cnt += int'(Scan_busy);
    done_cnt += int'(Scan_done);
    if (Eat_pulse) begin
      eat_cnt++;
      last_eat = cyc;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare();
  endtask

  task automatic clear_obs();
    busy_cnt = 0;
    done_cnt = 0;
    eat_cnt  = 0;
    pow_cnt  = 0;
    last_eat = -1;
  endtask

  // start a scan; optionally re-strobe Frame_tick, restart, or move pac-man at edge T+i
  task automatic run_scan(input int extra_at, input int restart_at, input int move_at, output int t0);
    clear_obs();
    Frame_tick = 1'b1;
    tick();
    t0 = cyc;
    Frame_tick = 1'b0;
    for (int i = 1; i <= N + 4; i++) begin
      Frame_tick    = (i == extra_at);
      Level_restart = (i == restart_at);
      if (i == move_at) begin
        Xp = 10'd100;
        Yp = 10'd100;
      end
      tick();
    end
    Frame_tick    = 1'b0;
    Level_restart = 1'b0;
  endtask

  task automatic restart_pulse();
    Level_restart = 1'b1;
    tick();
    Level_restart = 1'b0;
    tick();
  endtask

  task automatic count_visible(output int cnt);
    cnt = 0;
    for (int i = 0; i < N; i++) begin
      bus.Draw_idx = IDX_W'(i);
      tick();
      cnt += int'(bus.Draw_visible);
    end
    bus.Draw_idx = IDX_W'(5);
  endtask

  task automatic set_pac(input int x, input int y, input int s);
    Xp    = 10'(x);
    Yp    = 10'(y);
    Sizep = 10'(s);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int vis;
    int score_before;
    checks = 0;
    errors = 0;
    cyc    = 0;
    m_active = 1'b0;
    m_t = 0; m_px = 0; m_py = 0; m_hf = 0;
    m_bmp = '1; m_score = 0;
    m_eat = 0; m_done = 0; m_busy = 0; m_lc = 0; m_pow = 0;
    clear_obs();
    for (int k = 0; k < N; k++) begin
      rom_x[k] = 20 + 12 * k;
      rom_y[k] = 700;
    end
    rom_x[5]  = 100;  rom_y[5]  = 100;
    rom_x[10] = 3;    rom_y[10] = 3;
    rom_x[11] = 1020; rom_y[11] = 1020;

    Reset = 1'b1; Frame_tick = 1'b0; Level_restart = 1'b0;
    set_pac(0, 0, 0);
    bus.Draw_idx = IDX_W'(5);
    repeat (3) tick();
    chk("reset_score", Score, 0);
    chk("reset_rom_addr", bus.Rom_addr, 0);
    chk("reset_busy", Scan_busy, 0);
    chk("reset_done", Scan_done, 0);
    chk("reset_eat", Eat_pulse, 0);
    chk("reset_level_clear", Level_clear, 0);
    Reset = 1'b0;
    tick();

    // nothing within reach: full-length scan, no eats
    set_pac(500, 500, 16);
    run_scan(-1, -1, -1, t0);
    chk("t1_busy_cycles", busy_cnt, 65);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_eats", eat_cnt, 0);
    chk("t1_score", Score, 0);
    count_visible(vis);
    chk("t1_visible", vis, 64);

    // cookie 5 at (100,100), box edge exactly on it (inclusive)
    set_pac(108, 92, 16);
    run_scan(-1, -1, -1, t0);
    chk("t2_eats", eat_cnt, 1);
    chk("t2_eat_offset", last_eat - t0, 7);
    chk("t2_score", Score, 10);
    bus.Draw_idx = IDX_W'(5);
    tick();
    chk("t2_visible5", bus.Draw_visible, 0);
    run_scan(-1, -1, -1, t0);
    chk("t2_repeat_eats", eat_cnt, 0);
    chk("t2_repeat_score", Score, 10);

    // one pixel outside; moving pac-man onto the cookie mid-scan must not count
    restart_pulse();
    set_pac(109, 100, 16);
    run_scan(-1, -1, 2, t0);
    chk("t3_miss_eats", eat_cnt, 0);
    set_pac(0, 0, 8);
    run_scan(-1, -1, -1, t0);
    chk("t3_low_corner_eats", eat_cnt, 1);
    chk("t3_low_corner_offset", last_eat - t0, 12);
    set_pac(1023, 1023, 8);
    run_scan(-1, -1, -1, t0);
    chk("t3_high_corner_eats", eat_cnt, 1);
    chk("t3_score", Score, 30);

    // extra Frame_tick while busy is ignored
    set_pac(500, 500, 16);
    run_scan(10, -1, -1, t0);
    chk("t4_busy_cycles", busy_cnt, 65);
    chk("t4_done_count", done_cnt, 1);

    // restart at cycle 20 aborts before cookie 40 would be eaten
    set_pac(500, 700, 4);
    run_scan(-1, 20, -1, t0);
    chk("t5_busy_cycles", busy_cnt, 20);
    chk("t5_done_count", done_cnt, 0);
    chk("t5_eats", eat_cnt, 0);
    chk("t5_score", Score, 30);
    count_visible(vis);
    chk("t5_visible", vis, 64);

    // reset in the middle of a scan
    clear_obs();
    Frame_tick = 1'b1;
    tick();
    Frame_tick = 1'b0;
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    chk("t6_score", Score, 0);
    chk("t6_busy", Scan_busy, 0);
    chk("t6_rom_addr", bus.Rom_addr, 0);
    Reset = 1'b0;
    tick();

    // cookie 2 is a pellet only when the feature is built in
    set_pac(44, 700, 8);
    score_before = int'(Score);
    run_scan(-1, -1, -1, t0);
    chk("t7_eats", eat_cnt, 1);
`ifdef COOKIE_POWER_PELLET_EN
    chk("t7_score_delta", int'(Score) - score_before, 50);
    chk("t7_power_with_eat", pow_cnt, 1);
`else
    chk("t7_score_delta", int'(Score) - score_before, 10);
`endif

    // box covers the whole board; repeated clears drive the score into saturation
    set_pac(512, 512, 1023);
    for (int r = 0; r < 103; r++) begin
      restart_pulse();
      run_scan(-1, -1, -1, t0);
    end
    chk("t8_last_eats", eat_cnt, 64);
    chk("t8_level_clear", Level_clear, 1);
    chk("t8_score_sat", Score, 65535);
    restart_pulse();
    chk("t8_level_clear_off", Level_clear, 0);
    chk("t8_score_held", Score, 65535);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
